// File: rtl/xnor_correlator.sv
// Serial pattern correlator: shifts a bit stream into a WIDTH-bit window, scores it against
// a pattern by XNOR-popcount and flags/counts matches. Optional X/Z input check: XNOR_CORR_XCHECK_EN.
module xnor_correlator #(
  parameter  int WIDTH = 8,
  parameter  int CNTW  = 16,
  localparam int SW    = $clog2(WIDTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            din_valid,
  input  logic            din,
  input  logic [WIDTH-1:0] pattern,
  input  logic [SW-1:0]   threshold,
  output logic            score_vld,
  output logic [SW-1:0]   score,
  output logic            match,
  output logic [CNTW-1:0] match_cnt,
  output logic            err_xz
);

  // Handshake: din is consumed on every rising edge where din_valid=1 and clr=0; there is
  // no backpressure. score_vld is a one-cycle strobe qualifying score and match.

  typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] win;
  logic [SW-1:0]    fill;
  logic             v1;
  logic             accept;
  logic             v1_d;
  logic [SW-1:0]    agree;
  logic             hit;

`ifdef XNOR_CORR_XCHECK_EN
  logic din_bad;

  // A sample carrying X/Z is dropped rather than shifted into the window.
  assign din_bad = din_valid && (din !== 1'b0) && (din !== 1'b1);
  assign accept  = din_valid && !din_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_xz <= 1'b0;
    end else if (clr) begin
      err_xz <= 1'b0;
    end else if (din_bad) begin
      err_xz <= 1'b1;
    end
  end
`else
  assign accept = din_valid;
  assign err_xz = 1'b0;
`endif

  function automatic logic [SW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [SW-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + SW'(v[i]);
    end
    return c;
  endfunction

  assign agree = popcount(~(win ^ pattern));
  assign hit   = (agree >= threshold);

  // A window is complete once the accepted sample brings fill to WIDTH.
  always_comb begin
    state_d = state_q;
    v1_d    = 1'b0;
    if (clr) begin
      state_d = FILL;
    end else begin
      case (state_q)
        FILL: begin
          if (accept && (fill == SW'(WIDTH - 1))) begin
            state_d = RUN;
            v1_d    = 1'b1;
          end
        end
        RUN: begin
          v1_d = accept;
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win  <= '0;
      fill <= '0;
      v1   <= 1'b0;
    end else if (clr) begin
      win  <= '0;
      fill <= '0;
      v1   <= 1'b0;
    end else begin
      v1 <= v1_d;
      if (accept) begin
        win <= {win[WIDTH-2:0], din};
        if (fill != SW'(WIDTH)) begin
          fill <= fill + SW'(1);
        end
      end
    end
  end

  // Stage 2: pattern and threshold are used as presented in the cycle v1 is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score_vld <= 1'b0;
      score     <= '0;
      match     <= 1'b0;
      match_cnt <= '0;
    end else if (clr) begin
      score_vld <= 1'b0;
      score     <= '0;
      match     <= 1'b0;
      match_cnt <= '0;
    end else begin
      score_vld <= v1;
      if (v1) begin
        score <= agree;
        match <= hit;
        if (hit && (match_cnt != '1)) begin
          match_cnt <= match_cnt + CNTW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_xnor_correlator.sv
// Bench for xnor_correlator: directed streams, expected results queued at issue time and
// checked by a monitor whenever score_vld fires; a second instance with CNTW=2 checks saturation.
module tb_xnor_correlator;

  localparam int WIDTH = 8;
  localparam int SW    = 4;
  localparam int QW    = 55;

  logic             clk = 1'b0;
  logic             rst, clr, din_valid, din;
  logic [WIDTH-1:0] pattern;
  logic [SW-1:0]    threshold;

  logic             score_vld, match, err_xz;
  logic [SW-1:0]    score;
  logic [15:0]      match_cnt;
  logic             score_vld2, match2, err_xz2;
  logic [SW-1:0]    score2;
  logic [1:0]       match_cnt2;

  xnor_correlator #(.WIDTH(WIDTH), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .clr(clr), .din_valid(din_valid), .din(din),
    .pattern(pattern), .threshold(threshold), .score_vld(score_vld), .score(score),
    .match(match), .match_cnt(match_cnt), .err_xz(err_xz)
  );

  xnor_correlator #(.WIDTH(WIDTH), .CNTW(2)) dut2 (
    .clk(clk), .rst(rst), .clr(clr), .din_valid(din_valid), .din(din),
    .pattern(pattern), .threshold(threshold), .score_vld(score_vld2), .score(score2),
    .match(match2), .match_cnt(match_cnt2), .err_xz(err_xz2)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  logic [QW-1:0] exp_q[$];
  logic [QW-1:0] e;
  int n_cmp = 0;
  int n_bad = 0;

  logic [WIDTH-1:0] win_m;
  int fill_m, cnt16_m, cnt2_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    win_m   = '0;
    fill_m  = 0;
    cnt16_m = 0;
    cnt2_m  = 0;
  endtask

  // Driver tasks
  task automatic send(input logic b, input bit push = 1'b1);
    int  sc;
    bit  m;
    @(negedge clk);
    clr       = 1'b0;
    din_valid = 1'b1;
    din       = b;
    win_m     = {win_m[WIDTH-2:0], b};
    if (fill_m < WIDTH) fill_m++;
    if (fill_m == WIDTH && push) begin
      sc = WIDTH - $countones(win_m ^ pattern);
      m  = (sc >= int'(threshold));
      if (m) begin
        if (cnt16_m < 65535) cnt16_m++;
        if (cnt2_m < 3) cnt2_m++;
      end
      exp_q.push_back({32'(cyc + 2), 2'(cnt2_m), 16'(cnt16_m), m, 4'(sc)});
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send(v[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din_valid = 1'b0;
      din       = 1'b0;
    end
  endtask

  task automatic do_clr();
    @(negedge clk);
    din_valid = 1'b0;
    clr       = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_reset();
  endtask

  // Monitor: pops and compares on every score_vld
  always @(negedge clk) begin
    if (!rst && (score_vld || score_vld2)) begin
      check("vld_pair", 32'(score_vld2), 32'(score_vld));
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_vld: got score_vld=1 expected none (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        check("latency_cyc", 32'(cyc), e[54:23]);
        check("score", 32'(score), 32'(e[3:0]));
        check("score2", 32'(score2), 32'(e[3:0]));
        check("match", 32'(match), 32'(e[4]));
        check("match_cnt", 32'(match_cnt), 32'(e[20:5]));
        check("match_cnt2", 32'(match_cnt2), 32'(e[22:21]));
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL timeout: got no end of stimulus expected finish");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

  logic [12:0] s5;

  initial begin
    rst = 1'b1; clr = 1'b0; din_valid = 1'b0; din = 1'b0;
    pattern = 8'hA5; threshold = 4'd8;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_vld", 32'(score_vld), 0);
    check("rst_score", 32'(score), 0);
    check("rst_match", 32'(match), 0);
    check("rst_cnt", 32'(match_cnt), 0);
    check("rst_err", 32'(err_xz), 0);

    // 1: exact match of A5 at threshold 8
    send_byte(8'hA5);
    idle(3);
    check("t1_score", 32'(score), 8);
    check("t1_match", 32'(match), 1);
    check("t1_cnt", 32'(match_cnt), 1);

    // 2: inverted stream scores 0
    do_clr();
    threshold = 4'd1;
    send_byte(8'h5A);
    idle(3);
    check("t2_score", 32'(score), 0);
    check("t2_match", 32'(match), 0);
    check("t2_cnt", 32'(match_cnt), 0);

    // 3: 7 samples then a stall, then the 8th
    do_clr();
    threshold = 4'd8;
    for (int i = 7; i >= 1; i--) send(pattern[i]);
    idle(10);
    check("t3_stall_vld", 32'(score_vld), 0);
    send(pattern[0]);
    idle(3);
    check("t3_score", 32'(score), 8);
    check("t3_cnt", 32'(match_cnt), 1);

    // 4: clr after 5 samples, then a full window
    do_clr();
    for (int i = 0; i < 5; i++) send(1'b1);
    do_clr();
    send_byte(8'hA5);
    idle(3);
    check("t4_score", 32'(score), 8);
    check("t4_cnt", 32'(match_cnt), 1);

    // 4b: clr on the cycle a score is pending discards it
    do_clr();
    for (int i = 7; i >= 1; i--) send(pattern[i]);
    send(pattern[0], 1'b0);
    do_clr();
    idle(3);
    check("t4b_score", 32'(score), 0);
    check("t4b_cnt", 32'(match_cnt), 0);

    // 5: threshold 0, 6 windows; CNTW=2 copy saturates at 3
    do_clr();
    threshold = 4'd0;
    s5 = 13'b1101001110001;
    for (int i = 12; i >= 0; i--) send(s5[i]);
    idle(3);
    check("t5_cnt", 32'(match_cnt), 6);
    check("t5_cnt2", 32'(match_cnt2), 3);

    // threshold above WIDTH never matches
    threshold = 4'd9;
    send(1'b1); send(1'b0); send(1'b1); send(1'b1);
    idle(3);
    check("thr9_match", 32'(match), 0);
    check("thr9_cnt", 32'(match_cnt), 6);

    // pattern change between windows
    pattern   = 8'h3C;
    threshold = 4'd4;
    send_byte(8'h3C);
    idle(3);
    check("pat_score", 32'(score), 8);

    // 6: X/Z handling
`ifdef XNOR_CORR_XCHECK_EN
    do_clr();
    threshold = 4'd8;
    for (int i = 7; i >= 5; i--) send(pattern[i]);
    @(negedge clk); din_valid = 1'b1; din = 1'bx;
    @(negedge clk); din_valid = 1'b1; din = 1'bz;
    idle(2);
    check("t6_err", 32'(err_xz), 1);
    for (int i = 4; i >= 0; i--) send(pattern[i]);
    idle(3);
    check("t6_score", 32'(score), 8);
`else
    @(negedge clk); din_valid = 1'b0; din = 1'bx;
    idle(2);
    check("t6_err", 32'(err_xz), 0);
    check("t6_err2", 32'(err_xz2), 0);
`endif

    idle(5);
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
